// File: rtl/counter_mod_n_pkg.sv
// counter_mod_n_pkg: shared constants and helpers for the modulo-N counter
package counter_mod_n_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int DIV_SIM = 1;
  localparam int DIV_BOARD = 100000;
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/counter_mod_n_clk_en_div.sv
// clk_en_div: free-running prescaler producing a one-cycle Tick every DIV cycles
module clk_en_div
  import counter_mod_n_pkg::*;
#(
  parameter int DIV = DIV_BOARD
) (
  input  logic Clk,
  input  logic Reset,
  output logic Tick
);
  localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  logic [PW-1:0] r_cnt;
  if (DIV < 1) begin : g_bad_div
    $fatal(1, "clk_en_div: DIV must be >= 1");
  end
  // prescaler runs 0..DIV-1 and returns to 0, independent of enable/load
  always_ff @(posedge Clk) begin
    if (Reset) r_cnt <= '0;
    else r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end
  assign Tick = r_cnt == LAST;
endmodule

// File: rtl/counter_mod_n.sv
// counter_mod_n: prescaled modulo-N up/down counter with load, terminal count and wrap pulse
module counter_mod_n
  import counter_mod_n_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULUS = 10,
  parameter int DIV = DIV_BOARD
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Count,
  output logic             Tick,
  output logic             TerminalCount,
  output logic             Wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0] MOD = (WIDTH + 1)'(MODULUS);
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             w_tick;
  logic             w_step;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_wrap_step;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH || DIV < 1) begin : g_bad_params
    $fatal(1, "counter_mod_n: MODULUS must be 2..2**WIDTH and DIV >= 1");
  end
  clk_en_div #(.DIV(DIV)) u_div (
    .Clk  (Clk),
    .Reset(Reset),
    .Tick (w_tick)
  );
  assign w_step = Enable & w_tick;
  assign w_at_max = r_count == MAX;
  assign w_at_zero = r_count == '0;
  assign w_load_val = ({1'b0, LoadValue} < MOD) ? LoadValue : MAX;
  assign w_wrap_step = ~Load & w_step & ((Up == DIR_UP) ? w_at_max : w_at_zero);
  // next count: load beats step; wrap is detected by compare so MODULUS=2**WIDTH works
  always_comb begin
    w_next = Load ? w_load_val
           : !w_step ? r_count
           : (Up == DIR_UP) ? (w_at_max ? '0 : r_count + 1'b1)
           : (w_at_zero ? MAX : r_count - 1'b1);
  end
  // count and wrap registers; reset discards any pending load or step
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap <= w_wrap_step;
    end
  end
  assign Count = r_count;
  assign Wrap = r_wrap;
  assign Tick = w_tick;
  assign TerminalCount = (Up == DIR_UP) ? w_at_max : w_at_zero;
endmodule

// File: tb/tb_counter_mod_n.sv
// tb_counter_mod_n: directed self-checking bench for counter_mod_n
module tb_counter_mod_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic up = 1'b1;
  logic ld = 1'b0;
  logic [3:0] ld_val = '0;
  logic [3:0] a_cnt, b_cnt, c_cnt;
  logic a_tick, b_tick, c_tick;
  logic a_tc, b_tc, c_tc;
  logic a_wrap, b_wrap, c_wrap;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  counter_mod_n #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_a (
    .Clk(clk), .Reset(rst), .Enable(en), .Up(up), .Load(ld), .LoadValue(ld_val),
    .Count(a_cnt), .Tick(a_tick), .TerminalCount(a_tc), .Wrap(a_wrap)
  );
  counter_mod_n #(.WIDTH(4), .MODULUS(10), .DIV(4)) u_b (
    .Clk(clk), .Reset(rst), .Enable(en), .Up(up), .Load(ld), .LoadValue(ld_val),
    .Count(b_cnt), .Tick(b_tick), .TerminalCount(b_tc), .Wrap(b_wrap)
  );
  counter_mod_n #(.WIDTH(4), .MODULUS(16), .DIV(1)) u_c (
    .Clk(clk), .Reset(rst), .Enable(en), .Up(up), .Load(ld), .LoadValue(ld_val),
    .Count(c_cnt), .Tick(c_tick), .TerminalCount(c_tc), .Wrap(c_wrap)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    // 1: mod-10 count up with DIV=1
    en = 1'b1; up = 1'b1; ld = 1'b0;
    do_reset();
    check("rst_cnt", a_cnt, 0);
    check("rst_wrap", a_wrap, 0);
    check("rst_tick_div1", a_tick, 1);
    check("rst_tc", a_tc, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("up_cnt", a_cnt, i % 10);
      check("up_wrap", a_wrap, (i == 10) ? 1 : 0);
      check("up_tc", a_tc, (i == 9) ? 1 : 0);
    end
    step();
    check("up_after_wrap_cnt", a_cnt, 1);
    check("up_after_wrap_wrap", a_wrap, 0);
    // 2: count down from 0
    do_reset();
    up = 1'b0;
    #1;
    check("dn_tc_at0", a_tc, 1);
    for (int i = 1; i <= 11; i++) begin
      step();
      check("dn_cnt", a_cnt, (20 - i) % 10);
      check("dn_wrap", a_wrap, (i == 1 || i == 11) ? 1 : 0);
      check("dn_tc", a_tc, (i == 10) ? 1 : 0);
    end
    // 3: DIV=4 prescaled stepping and enable freeze
    up = 1'b1;
    do_reset();
    check("div4_rst_tick", b_tick, 0);
    check("div4_rst_cnt", b_cnt, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("div4_tick", b_tick, (k % 4 == 3) ? 1 : 0);
      check("div4_cnt", b_cnt, k / 4);
    end
    en = 1'b0;
    for (int k = 13; k <= 20; k++) begin
      step();
      check("en0_hold", b_cnt, 3);
      check("en0_tick", b_tick, (k % 4 == 3) ? 1 : 0);
    end
    en = 1'b1;
    for (int k = 21; k <= 24; k++) begin
      step();
      check("en1_resume", b_cnt, (k == 24) ? 4 : 3);
    end
    // 4: load, clamp, and load over a step
    ld = 1'b1; ld_val = 4'd7;
    step();
    check("ld7_cnt", a_cnt, 7);
    check("ld7_wrap", a_wrap, 0);
    ld_val = 4'd12;
    step();
    check("ld12_clamp", a_cnt, 9);
    check("ld12_wrap", a_wrap, 0);
    ld_val = 4'd3;
    step();
    check("ld_over_step_cnt", a_cnt, 3);
    check("ld_over_step_wrap", a_wrap, 0);
    ld = 1'b0;
    step();
    check("after_ld_step", a_cnt, 4);
    // 5: full-range modulus 16
    do_reset();
    for (int i = 1; i <= 15; i++) step();
    check("m16_cnt15", c_cnt, 15);
    check("m16_tc15", c_tc, 1);
    step();
    check("m16_wrap_cnt", c_cnt, 0);
    check("m16_wrap", c_wrap, 1);
    up = 1'b0;
    step();
    check("m16_dn_cnt", c_cnt, 15);
    check("m16_dn_wrap", c_wrap, 1);
    step();
    check("m16_dn_cnt14", c_cnt, 14);
    check("m16_dn_wrap0", c_wrap, 0);
    // 6: reset mid-prescale with a pending load
    up = 1'b1;
    do_reset();
    for (int k = 1; k <= 22; k++) step();
    check("mid_cnt5", b_cnt, 5);
    rst = 1'b1; ld = 1'b1; ld_val = 4'd7;
    step();
    check("mid_rst_cnt", b_cnt, 0);
    check("mid_rst_wrap", b_wrap, 0);
    check("mid_rst_tick", b_tick, 0);
    rst = 1'b0; ld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("post_rst_tick", b_tick, (k == 3) ? 1 : 0);
      check("post_rst_cnt", b_cnt, (k == 4) ? 1 : 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
